tick_bcd_counter: RTL and testbench

- Downstream consumer of the divide-by-10 clock divider output.
- Samples the divided square wave in the `clk` domain and converts each rising edge into a one-cycle `tick`.
- Counts ticks in a two-digit BCD counter with enable, clear and a programmable terminal value.
- Forms the seconds/minutes-style counting stage that feeds display and timer logic.

---
 rtl/tick_bcd_counter.sv | 84 ++++++++
 tb/tb_tick_bcd_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_bcd_counter.sv
// Converts rising edges of a divided square wave into one-cycle ticks.
// The ticks drive a two-digit BCD counter with clear, enable and a programmable terminal count.
module tick_bcd_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59,
  parameter bit         WRAP    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slow_clk_in,
  input  logic       enable,
  input  logic       clear,
  output logic       tick,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       rollover,
  output logic       at_max
);

  localparam logic [3:0] MAX_ONES = MAX_BCD[3:0];
  localparam logic [3:0] MAX_TENS = MAX_BCD[7:4];

  logic       r_prev_q;
  logic       r_tick;
  logic       r_rollover;
  logic [3:0] r_ones;
  logic [3:0] r_tens;

  logic       w_edge;
  logic       w_at_max;
  logic       w_count;
  logic [3:0] w_ones_inc;
  logic [3:0] w_tens_inc;

  // slow_clk_in comes from the same clock domain, so one register suffices for edge detection
  assign w_edge   = slow_clk_in & ~r_prev_q;
  assign w_at_max = (r_ones == MAX_ONES) && (r_tens == MAX_TENS);
  assign w_count  = enable & w_edge;

  always_comb begin
    w_ones_inc = r_ones + 4'd1;
    w_tens_inc = r_tens;
    if (r_ones == 4'd9) begin
      w_ones_inc = 4'd0;
      w_tens_inc = r_tens + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_q   <= 1'b0;
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
      r_ones     <= 4'd0;
      r_tens     <= 4'd0;
    end else begin
      r_prev_q   <= slow_clk_in;
      r_tick     <= w_edge;
      r_rollover <= 1'b0;
      if (clear) begin
        r_ones <= 4'd0;
        r_tens <= 4'd0;
      end else if (w_count) begin
        if (w_at_max) begin
          // Saturating mode simply holds at the terminal value
          if (WRAP) begin
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_rollover <= 1'b1;
          end
        end else begin
          r_ones <= w_ones_inc;
          r_tens <= w_tens_inc;
        end
      end
    end
  end

  assign tick     = r_tick;
  assign ones     = r_ones;
  assign tens     = r_tens;
  assign rollover = r_rollover;
  assign at_max   = w_at_max;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: a wrapping 59 instance and a saturating 23 instance share stimulus
// and are checked every cycle against an integer-count model, plus directed literal checks.
module tb_tick_bcd_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slow_clk_in = 1'b0;
  logic enable = 1'b1;
  logic clear = 1'b0;

  logic       d_tick[2];
  logic [3:0] d_ones[2];
  logic [3:0] d_tens[2];
  logic       d_roll[2];
  logic       d_max[2];

  always #5 clk = ~clk;

  tick_bcd_counter #(.MAX_BCD(8'h59), .WRAP(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .slow_clk_in(slow_clk_in), .enable(enable), .clear(clear),
    .tick(d_tick[0]), .ones(d_ones[0]), .tens(d_tens[0]), .rollover(d_roll[0]), .at_max(d_max[0])
  );

  tick_bcd_counter #(.MAX_BCD(8'h23), .WRAP(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .slow_clk_in(slow_clk_in), .enable(enable), .clear(clear),
    .tick(d_tick[1]), .ones(d_ones[1]), .tens(d_tens[1]), .rollover(d_roll[1]), .at_max(d_max[1])
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Model: the count is a plain integer 0..max, digits are derived by division
  int m_max[2]  = '{59, 23};
  bit m_wrap[2] = '{1'b1, 1'b0};
  int m_n[2]    = '{0, 0};
  bit m_tick    = 1'b0;
  bit m_roll[2] = '{1'b0, 1'b0};
  bit m_last_in = 1'b0;

  always @(posedge clk) begin
    bit rise;
    if (reset) begin
      m_last_in = 1'b0;
      m_tick    = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_n[i]    = 0;
        m_roll[i] = 1'b0;
      end
    end else begin
      rise      = slow_clk_in && !m_last_in;
      m_last_in = slow_clk_in;
      m_tick    = rise;
      for (int i = 0; i < 2; i++) begin
        m_roll[i] = 1'b0;
        if (clear) m_n[i] = 0;
        else if (enable && rise) begin
          if (m_n[i] < m_max[i]) m_n[i] = m_n[i] + 1;
          else if (m_wrap[i]) begin
            m_n[i]    = 0;
            m_roll[i] = 1'b1;
          end
        end
      end
    end
  end

  int tick_cnt[2] = '{0, 0};
  int roll_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tick%0d", i), 32'(d_tick[i]), 32'(m_tick));
      check($sformatf("ones%0d", i), 32'(d_ones[i]), 32'(m_n[i] % 10));
      check($sformatf("tens%0d", i), 32'(d_tens[i]), 32'(m_n[i] / 10));
      check($sformatf("roll%0d", i), 32'(d_roll[i]), 32'(m_roll[i]));
      check($sformatf("atmax%0d", i), 32'(d_max[i]), 32'(m_n[i] == m_max[i]));
      if (d_tick[i] === 1'b1) tick_cnt[i]++;
      if (d_roll[i] === 1'b1) roll_cnt[i]++;
    end
  end

  task automatic hold(input logic s, input int n);
    slow_clk_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic period(input int n);
    repeat (n) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
  endtask

  task automatic do_reset();
    slow_clk_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] cnt(input int i);
    return {d_tens[i], d_ones[i]};
  endfunction

  int t0, t1;

  initial begin
    @(negedge clk);
    check("reset_cnt0", 32'(cnt(0)), 32'h00);
    check("reset_tick0", 32'(d_tick[0]), 32'h0);
    reset = 1'b0;

    // Divider-style input, 12 ticks
    enable = 1'b1;
    do_reset();
    period(12);
    check("t1_cnt", 32'(cnt(0)), 32'h12);
    $display("txn test1: count=%h", cnt(0));

    // Wrap at 59 on dut0, saturate at 23 on dut1
    do_reset();
    t0 = tick_cnt[1];
    period(30);
    check("t3_cnt", 32'(cnt(1)), 32'h23);
    check("t3_atmax", 32'(d_max[1]), 32'h1);
    check("t3_roll", 32'(roll_cnt[1]), 32'h0);
    check("t3_ticks", 32'(tick_cnt[1] - t0), 32'd30);
    $display("txn test3: count=%h ticks=%0d", cnt(1), tick_cnt[1] - t0);
    period(29);
    check("t2_cnt59", 32'(cnt(0)), 32'h59);
    check("t2_atmax", 32'(d_max[0]), 32'h1);
    t1 = roll_cnt[0];
    period(1);
    check("t2_cnt00", 32'(cnt(0)), 32'h00);
    check("t2_roll", 32'(roll_cnt[0] - t1), 32'h1);
    $display("txn test2: count=%h rollovers=%0d", cnt(0), roll_cnt[0] - t1);

    // Clear coinciding with a detected edge
    do_reset();
    period(7);
    check("t4_cnt07", 32'(cnt(0)), 32'h07);
    clear = 1'b1;
    slow_clk_in = 1'b1;
    @(negedge clk);
    check("t4_tick", 32'(d_tick[0]), 32'h1);
    check("t4_cnt00", 32'(cnt(0)), 32'h00);
    clear = 1'b0;
    hold(1'b1, 4);
    hold(1'b0, 5);
    period(1);
    check("t4_cnt01", 32'(cnt(0)), 32'h01);
    $display("txn test4: count=%h", cnt(0));

    // Disabled edges still tick
    enable = 1'b0;
    t0 = tick_cnt[0];
    period(3);
    check("t5_ticks", 32'(tick_cnt[0] - t0), 32'd3);
    check("t5_hold", 32'(cnt(0)), 32'h01);
    enable = 1'b1;
    period(1);
    check("t5_cnt02", 32'(cnt(0)), 32'h02);
    $display("txn test5: count=%h", cnt(0));

    // Reset mid-count with the input high
    do_reset();
    period(34);
    check("t6_cnt34", 32'(cnt(0)), 32'h34);
    slow_clk_in = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_rst_cnt", 32'(cnt(0)), 32'h00);
    check("t6_rst_tick", 32'(d_tick[0]), 32'h0);
    check("t6_rst_max", 32'(d_max[0]), 32'h0);
    @(negedge clk);
    check("t6_tick", 32'(d_tick[0]), 32'h1);
    check("t6_cnt01", 32'(cnt(0)), 32'h01);
    $display("txn test6: count=%h", cnt(0));
    hold(1'b1, 3);
    hold(1'b0, 5);

    // Randomized traffic: single-cycle pulses, toggling, holds, rare clear/reset
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 3))
        0: slow_clk_in = ~slow_clk_in;
        1: slow_clk_in = 1'($urandom_range(0, 1));
        default: ;
      endcase
      enable = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 399) == 0);
      reset  = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    clear = 1'b0;
    $display("txn random: ticks0=%0d rollovers0=%0d", tick_cnt[0], roll_cnt[0]);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
